ffstdp_sched: RTL and testbench
===============================

FFSTDP_SCHED -- requirements
Module: ffstdp_sched

Interface
- REQ-001 Parameter PRE_NUM, default 256: presynaptic inputs per neuron; power of two, at least 2.
- REQ-002 Parameter POST_NUM, default 128: postsynaptic neurons; power of two, at least 1.
- REQ-003 Parameter ADDR_WIDTH, default $clog2(PRE_NUM)+$clog2(POST_NUM): synapse SRAM address width.
- REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
- REQ-005 RST_N  in  1  synchronous, active-low reset.
- REQ-006 START  in  1  one-cycle request to sweep all synapses.
- REQ-007 ABORT  in  1  stop issuing new synapses; in-flight synapses still complete.
- REQ-008 GNT  in  1  SRAM read-port grant from arbiter; no read issue while low.
- REQ-009 IS_TRAIN_IN / IS_POS_IN  in  1 each  sweep configuration, sampled only on accepted START.
- REQ-010 SRAM_RE  out  1  read enable.
- REQ-011 SRAM_RADDR  out  ADDR_WIDTH  read address.
- REQ-012 SRAM_WE  out  1  write enable for update-datapath result.
- REQ-013 SRAM_WADDR  out  ADDR_WIDTH  write address.
- REQ-014 CTRL_TREF_EVENT  out  1  update strobe to datapath.
- REQ-015 IS_TRAIN / IS_POS  out  1 each  latched configuration to datapath.
- REQ-016 PRE_IDX  out  $clog2(PRE_NUM)  and POST_IDX  out  $clog2(POST_NUM): write-stage indices selecting spike counters.
- REQ-017 BUSY  out  1  sweep in progress.
- REQ-018 DONE  out  1  one-cycle completion pulse.

Function
- REQ-019 FSM states: IDLE, RUN, DRAIN, FIN.
- REQ-020 IDLE->RUN on START; START outside IDLE is ignored.
- REQ-021 Accepted START clears both counters and latches IS_TRAIN_IN into IS_TRAIN and IS_POS_IN into IS_POS.
- REQ-022 In RUN, each cycle with GNT=1: SRAM_RE=1 and SRAM_RADDR={post_cnt, pre_cnt}; then advance pre_cnt; on wrap from PRE_NUM-1 to 0, also advance post_cnt.
- REQ-023 In RUN with GNT=0: SRAM_RE=0 and counters hold.
- REQ-024 RUN->DRAIN in the cycle that issues the last address (post_cnt=POST_NUM-1, pre_cnt=PRE_NUM-1), or on ABORT; ABORT in an issuing cycle still issues that cycle's read.
- REQ-025 Two-stage valid/address pipeline (SRAM read latency 1 + datapath register 1): an issue in cycle t gives, in cycle t+2, SRAM_WE=1, CTRL_TREF_EVENT=1, SRAM_WADDR = the issued address, and PRE_IDX/POST_IDX = its fields.
- REQ-026 Pipeline stages advance every cycle regardless of GNT; the write port is never stalled.
- REQ-027 DRAIN->FIN when both pipeline stages are empty.
- REQ-028 FIN asserts DONE for exactly one cycle, then ->IDLE.
- REQ-029 BUSY=1 in RUN and DRAIN, 0 in IDLE and FIN.
- REQ-030 With GNT held high: START sampled at edge 0, N=PRE_NUM*POST_NUM.
  - SRAM_RE high in cycles 1..N.
  - SRAM_WE high in cycles 3..N+2.
  - DONE high in cycle N+3.
- REQ-031 Counters use unsigned wrap arithmetic; the address is a plain concatenation with no multiplier.
- REQ-032 SRAM_WE, CTRL_TREF_EVENT, PRE_IDX and POST_IDX are registered outputs, glitch-free.
- REQ-033 When SRAM_WE=0, SRAM_WADDR, PRE_IDX and POST_IDX hold their last values.

Reset
- REQ-034 RST_N=0 at a clock edge forces: state IDLE; counters and pipeline valids 0; all outputs 0 (IS_TRAIN=0, IS_POS=0).
- REQ-035 Reset overrides START and ABORT in the same cycle.
- REQ-036 Reset mid-sweep discards in-flight writes: no SRAM_WE and no DONE afterwards until a new START.

Verification (PRE_NUM=4, POST_NUM=2, N=8)
- REQ-037 Full sweep:
  - Stimulus: START with GNT=1, IS_TRAIN_IN=1, IS_POS_IN=0.
  - Response: RADDR 0..7 in cycles 1-8; WADDR 0..7 with CTRL_TREF_EVENT in cycles 3-10; DONE in cycle 11; IS_TRAIN=1 and IS_POS=0 throughout.
- REQ-038 Grant stall:
  - Stimulus: GNT=0 in cycles 3-4.
  - Response: addresses 0,1 issued in cycles 1-2; address 2 in cycle 5; no writes in cycles 5-6; sequence gap-free and ordered; DONE in cycle 13.
- REQ-039 Abort:
  - Stimulus: ABORT in cycle 3.
  - Response: reads 0,1,2 only; writes 0,1,2 in cycles 3-5; DONE in cycle 6.
- REQ-040 Ignored START:
  - Stimulus: START pulsed in cycle 4 of a sweep with IS_POS_IN toggled.
  - Response: no counter restart; IS_POS unchanged; exactly 8 writes; a single DONE.
- REQ-041 Reset mid-sweep:
  - Stimulus: RST_N=0 in cycle 5.
  - Response: next cycle all outputs 0; no further SRAM_WE or DONE until a new START.
- REQ-042 Back-to-back:
  - Stimulus: START in the DONE cycle is ignored; START one cycle later is accepted.
  - Response: the second sweep repeats REQ-037 timing.

Source files
------------

// File: rtl/ffstdp_sched.sv
`default_nettype none
// ============================================================================
// Module      : ffstdp_sched
// Description : Synapse sweep scheduler for the STDP update engine. Walks
//               every (post, pre) synapse address through the shared SRAM
//               read port, then replays each address two cycles later as a
//               write strobe to the update datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module ffstdp_sched #(
  parameter int PRE_NUM    = 256,
  parameter int POST_NUM   = 128,
  parameter int ADDR_WIDTH = $clog2(PRE_NUM) + $clog2(POST_NUM)
) (
  input  logic                                              CLK,
  input  logic                                              RST_N,
  input  logic                                              START,
  input  logic                                              ABORT,
  input  logic                                              GNT,
  input  logic                                              IS_TRAIN_IN,
  input  logic                                              IS_POS_IN,
  output logic                                              SRAM_RE,
  output logic [ADDR_WIDTH-1:0]                             SRAM_RADDR,
  output logic                                              SRAM_WE,
  output logic [ADDR_WIDTH-1:0]                             SRAM_WADDR,
  output logic                                              CTRL_TREF_EVENT,
  output logic                                              IS_TRAIN,
  output logic                                              IS_POS,
  output logic [$clog2(PRE_NUM)-1:0]                        PRE_IDX,
  output logic [((POST_NUM > 1) ? $clog2(POST_NUM) : 1)-1:0] POST_IDX,
  output logic                                              BUSY,
  output logic                                              DONE
);

  localparam int PRE_W  = $clog2(PRE_NUM);
  // A single postsynaptic neuron still needs a 1-bit counter to stay legal.
  localparam int POST_W = (POST_NUM > 1) ? $clog2(POST_NUM) : 1;
  localparam int FULL_W = PRE_W + POST_W;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_NUM - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_NUM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [POST_W-1:0]   post_cnt_q, post_cnt_d;
  logic                is_train_q, is_train_d;
  logic                is_pos_q, is_pos_d;

  // Stage 1 tracks the read in flight to the SRAM, stage 2 the datapath
  // register; stage 2 directly drives the write-side outputs.
  logic                v1_q, v1_d;
  logic [FULL_W-1:0]   a1_q, a1_d;
  logic                v2_q, v2_d;
  logic [FULL_W-1:0]   a2_q, a2_d;

  logic                issue;
  logic                last_addr;
  logic [FULL_W-1:0]   raddr_full;

  assign raddr_full = {post_cnt_q, pre_cnt_q};
  assign last_addr  = (post_cnt_q == POST_LAST) && (pre_cnt_q == PRE_LAST);

  // Next-state, counter advance and configuration latch for the sweep FSM.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    is_train_d = is_train_q;
    is_pos_d   = is_pos_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = RUN;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          is_train_d = IS_TRAIN_IN;
          is_pos_d   = IS_POS_IN;
        end
      end
      RUN: begin
        if (GNT) begin
          issue     = 1'b1;
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_q == PRE_LAST) begin
            post_cnt_d = post_cnt_q + 1'b1;
          end
        end
        // An abort in a granted cycle still lets that cycle's read go out.
        if ((GNT && last_addr) || ABORT) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Nothing issues in DRAIN, so once stage 1 is empty both stages are
        // empty after this edge and FIN lines up with the last write + 1.
        if (!v1_q) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read-to-write pipeline; it advances every cycle and never stalls on GNT.
  always_comb begin
    v1_d = issue;
    a1_d = issue ? raddr_full : a1_q;
    v2_d = v1_q;
    a2_d = v1_q ? a1_q : a2_q;
  end

  // State, counters, configuration and pipeline registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      is_train_q <= 1'b0;
      is_pos_q   <= 1'b0;
      v1_q       <= 1'b0;
      a1_q       <= '0;
      v2_q       <= 1'b0;
      a2_q       <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      is_train_q <= is_train_d;
      is_pos_q   <= is_pos_d;
      v1_q       <= v1_d;
      a1_q       <= a1_d;
      v2_q       <= v2_d;
      a2_q       <= a2_d;
    end
  end

  assign SRAM_RE         = issue;
  assign SRAM_RADDR      = raddr_full[ADDR_WIDTH-1:0];
  assign SRAM_WE         = v2_q;
  assign CTRL_TREF_EVENT = v2_q;
  assign SRAM_WADDR      = a2_q[ADDR_WIDTH-1:0];
  assign PRE_IDX         = a2_q[PRE_W-1:0];
  assign POST_IDX        = a2_q[FULL_W-1:PRE_W];
  assign IS_TRAIN        = is_train_q;
  assign IS_POS          = is_pos_q;
  assign BUSY            = (state_q == RUN) || (state_q == DRAIN);
  assign DONE            = (state_q == FIN);

endmodule
`default_nettype wire

// File: tb/tb_ffstdp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ffstdp_sched
// Description : Self-checking bench for ffstdp_sched (PRE_NUM=4, POST_NUM=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ffstdp_sched;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       GNT = 1'b0;
  logic       IS_TRAIN_IN = 1'b0;
  logic       IS_POS_IN = 1'b0;
  logic       SRAM_RE;
  logic [2:0] SRAM_RADDR;
  logic       SRAM_WE;
  logic [2:0] SRAM_WADDR;
  logic       CTRL_TREF_EVENT;
  logic       IS_TRAIN;
  logic       IS_POS;
  logic [1:0] PRE_IDX;
  logic [0:0] POST_IDX;
  logic       BUSY;
  logic       DONE;

  ffstdp_sched #(.PRE_NUM(4), .POST_NUM(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .GNT(GNT),
    .IS_TRAIN_IN(IS_TRAIN_IN), .IS_POS_IN(IS_POS_IN),
    .SRAM_RE(SRAM_RE), .SRAM_RADDR(SRAM_RADDR), .SRAM_WE(SRAM_WE),
    .SRAM_WADDR(SRAM_WADDR), .CTRL_TREF_EVENT(CTRL_TREF_EVENT),
    .IS_TRAIN(IS_TRAIN), .IS_POS(IS_POS), .PRE_IDX(PRE_IDX),
    .POST_IDX(POST_IDX), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int stall_from;   // first cycle with GNT=0 (-1: none)
    int stall_to;     // last cycle with GNT=0
    int abort_cyc;    // cycle with ABORT=1 (-1: none)
    int extra_start;  // extra START pulse that must be ignored (-1: none)
    bit train;
    bit pos;
    int exp_reads;    // number of addresses that must be issued
    int exp_done;     // cycle in which DONE must pulse
    int tail;         // idle cycles checked after DONE
  } scen_t;

  typedef struct {
    int addr;
    int due;
  } wr_t;

  scen_t tbl[9];
  wr_t   wq[$];
  int    total = 0;
  int    bad = 0;
  int    scen_id = 0;
  int    cyc = 0;
  int    last_wa = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: scen %0d cycle %0d got %0d want %0d", nm, scen_id, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero();
    chk("z_re", {31'd0, SRAM_RE}, 0);
    chk("z_raddr", {29'd0, SRAM_RADDR}, 0);
    chk("z_we", {31'd0, SRAM_WE}, 0);
    chk("z_waddr", {29'd0, SRAM_WADDR}, 0);
    chk("z_tref", {31'd0, CTRL_TREF_EVENT}, 0);
    chk("z_is_train", {31'd0, IS_TRAIN}, 0);
    chk("z_is_pos", {31'd0, IS_POS}, 0);
    chk("z_pre_idx", {30'd0, PRE_IDX}, 0);
    chk("z_post_idx", {31'd0, POST_IDX}, 0);
    chk("z_busy", {31'd0, BUSY}, 0);
    chk("z_done", {31'd0, DONE}, 0);
  endtask

  // One sweep: cycle 0 carries the START; expected reads are 0,1,2.. in
  // granted cycles, and each read is queued to reappear as a write 2 later.
  task automatic run_scen(input int id, input scen_t s);
    int   issued;
    logic gnt;
    logic exp_re;
    logic exp_we;
    wr_t  w;
    issued  = 0;
    scen_id = id;
    wq.delete();
    for (int c = 0; c <= s.exp_done + s.tail; c++) begin
      tick();
      cyc = c;
      gnt = !(c >= s.stall_from && c <= s.stall_to);
      START       = (c == 0) || (c == s.extra_start);
      GNT         = gnt;
      ABORT       = (c == s.abort_cyc);
      IS_TRAIN_IN = (c == 0) ? s.train : !s.train;
      IS_POS_IN   = (c == 0) ? s.pos : !s.pos;
      #2;
      exp_re = (c >= 1) && gnt && (issued < s.exp_reads);
      chk("re", {31'd0, SRAM_RE}, {31'd0, exp_re});
      if (exp_re) begin
        chk("raddr", {29'd0, SRAM_RADDR}, issued);
        w.addr = issued;
        w.due  = c + 2;
        wq.push_back(w);
        issued++;
      end
      exp_we = (wq.size() > 0) && (wq[0].due == c);
      chk("we", {31'd0, SRAM_WE}, {31'd0, exp_we});
      chk("tref", {31'd0, CTRL_TREF_EVENT}, {31'd0, exp_we});
      if (exp_we) begin
        w = wq.pop_front();
        last_wa = w.addr;
      end
      chk("waddr", {29'd0, SRAM_WADDR}, last_wa);
      chk("pre_idx", {30'd0, PRE_IDX}, last_wa % 4);
      chk("post_idx", {31'd0, POST_IDX}, last_wa / 4);
      chk("done", {31'd0, DONE}, (c == s.exp_done) ? 1 : 0);
      chk("busy", {31'd0, BUSY}, (c >= 1 && c < s.exp_done) ? 1 : 0);
      if (c >= 1) begin
        chk("is_train", {31'd0, IS_TRAIN}, {31'd0, s.train});
        chk("is_pos", {31'd0, IS_POS}, {31'd0, s.pos});
      end
    end
    chk("wq_empty", wq.size(), 0);
    chk("reads", issued, s.exp_reads);
  endtask

  initial begin
    //        stall_f stall_t abort extra tr  pos reads done tail
    tbl[0] = '{-1, -1, -1, -1, 1'b1, 1'b0, 8, 11, 2};  // full sweep
    tbl[1] = '{ 3,  4, -1, -1, 1'b1, 1'b1, 8, 13, 2};  // grant stall 3-4
    tbl[2] = '{-1, -1,  3, -1, 1'b0, 1'b1, 3,  6, 2};  // abort in cycle 3
    tbl[3] = '{-1, -1, -1,  4, 1'b1, 1'b0, 8, 11, 2};  // START mid-sweep ignored
    tbl[4] = '{ 3,  5,  4, -1, 1'b0, 1'b0, 2,  6, 2};  // abort while stalled
    tbl[5] = '{ 1,  1, -1, -1, 1'b1, 1'b1, 8, 12, 2};  // stall on first cycle
    tbl[6] = '{-1, -1, -1, 11, 1'b1, 1'b0, 8, 11, 0};  // START in DONE cycle
    tbl[7] = '{-1, -1, -1, -1, 1'b0, 1'b0, 8, 11, 2};  // accepted right after
    tbl[8] = '{-1, -1,  1, -1, 1'b1, 1'b1, 1,  4, 2};  // abort on first issue

    // Reset state.
    RST_N = 1'b0;
    tick();
    tick();
    scen_id = 100;
    cyc = 0;
    #2;
    chk_all_zero();
    tick();
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_scen(i, tbl[i]);
    end

    // Reset mid-sweep, with START and ABORT present at the reset edge.
    scen_id = 99;
    for (int c = 0; c <= 16; c++) begin
      tick();
      cyc = c;
      RST_N       = (c != 5);
      START       = (c == 0) || (c == 5);
      ABORT       = (c == 5);
      GNT         = 1'b1;
      IS_TRAIN_IN = 1'b1;
      IS_POS_IN   = 1'b1;
      #2;
      if (c == 3) begin
        chk("rst_pre_busy", {31'd0, BUSY}, 1);
      end
      if (c == 6) begin
        chk_all_zero();
      end
      if (c >= 6) begin
        chk("rst_we", {31'd0, SRAM_WE}, 0);
        chk("rst_done", {31'd0, DONE}, 0);
        chk("rst_re", {31'd0, SRAM_RE}, 0);
        chk("rst_busy", {31'd0, BUSY}, 0);
      end
    end
    last_wa = 0;

    // Recovery sweep after reset.
    run_scen(9, tbl[0]);

    tick();
    START = 1'b0;
    ABORT = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
